flop_rc: RTL and testbench



---
 rtl/flop_rc_pkg.sv | 14 +
 rtl/flop_rc.sv | 44 ++++
 tb/tb_flop_rc.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/flop_rc_pkg.sv
/*------------------------------------------------------------------------------
 * Module : flop_rc_pkg
 * Shared defaults for the pipeline stage register family.
 * Rev    : 1.0  initial release
 *----------------------------------------------------------------------------*/
`default_nettype none

package flop_rc_pkg;

  localparam int unsigned FLOP_RC_DEFAULT_WIDTH = 8;

endpackage : flop_rc_pkg

`default_nettype wire

// File: rtl/flop_rc.sv
/*------------------------------------------------------------------------------
 * Module : flop_rc
 * Pipeline stage register: async active-low reset, sync clear, load d.
 * Rev    : 1.0  initial release
 *----------------------------------------------------------------------------*/
`default_nettype none

module flop_rc
  import flop_rc_pkg::*;
#(
  parameter int unsigned            WIDTH     = FLOP_RC_DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0]       RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

  // Clear inserts a bubble by loading the same value reset would.
  always_comb begin
    q_d = d;
    if (clear) begin
      q_d = RESET_VAL;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q_q <= RESET_VAL;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule : flop_rc

`default_nettype wire

// File: tb/tb_flop_rc.sv
/*------------------------------------------------------------------------------
 * Module : tb_flop_rc
 * Self-checking bench for flop_rc with a scoreboard of expected q values.
 * Rev    : 1.0  initial release
 *----------------------------------------------------------------------------*/
`default_nettype none

module tb_flop_rc;

  logic       clk;
  logic       reset;
  logic       clear;
  logic [7:0] d;
  logic [7:0] q;

  int         checks;
  int         failures;
  logic [7:0] exp_q[$];
  logic [7:0] exp_v;

  flop_rc #(
    .WIDTH    (8),
    .RESET_VAL(8'h00)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .clear(clear),
    .d    (d),
    .q    (q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, q=%h required finish", q);
    $fatal(1, "watchdog");
  end

  task automatic test_reset();
    reset = 1'b0;
    clear = 1'b0;
    d     = 8'hA5;
    #1;
    checks++;
    if (q !== 8'h00) begin
      failures++;
      $display("FAIL reset_before_edge: q=%h required=%h", q, 8'h00);
    end
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back(8'h00);
      @(posedge clk);
      #1;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL reset_hold_sb: scoreboard empty, q=%h", q);
      end else begin
        exp_v = exp_q.pop_front();
        if (q !== exp_v) begin
          failures++;
          $display("FAIL reset_hold_%0d: q=%h required=%h", i, q, exp_v);
        end
      end
    end
  endtask

  task automatic test_release_load();
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (q !== 8'h00) begin
      failures++;
      $display("FAIL release_no_change: q=%h required=%h", q, 8'h00);
    end
    exp_q.push_back(8'hA5);
    @(posedge clk);
    #1;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL release_load_sb: scoreboard empty, q=%h", q);
    end else begin
      exp_v = exp_q.pop_front();
      if (q !== exp_v) begin
        failures++;
        $display("FAIL release_load: q=%h required=%h", q, exp_v);
      end
    end
    d = 8'h77;
    @(negedge clk);
    #1;
    checks++;
    if (q !== 8'hA5) begin
      failures++;
      $display("FAIL falling_edge_ignored: q=%h required=%h", q, 8'hA5);
    end
  endtask

  task automatic test_sync_clear();
    clear = 1'b1;
    d     = 8'h3C;
    #1;
    checks++;
    if (q !== 8'hA5) begin
      failures++;
      $display("FAIL clear_before_edge: q=%h required=%h", q, 8'hA5);
    end
    exp_q.push_back(8'h00);
    @(posedge clk);
    #1;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL clear_edge_sb: scoreboard empty, q=%h", q);
    end else begin
      exp_v = exp_q.pop_front();
      if (q !== exp_v) begin
        failures++;
        $display("FAIL clear_edge: q=%h required=%h", q, exp_v);
      end
    end
    clear = 1'b0;
    exp_q.push_back(8'h3C);
    @(posedge clk);
    #1;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL clear_release_sb: scoreboard empty, q=%h", q);
    end else begin
      exp_v = exp_q.pop_front();
      if (q !== exp_v) begin
        failures++;
        $display("FAIL clear_release: q=%h required=%h", q, exp_v);
      end
    end
  endtask

  task automatic test_async_reset();
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (q !== 8'h00) begin
      failures++;
      $display("FAIL async_reset_immediate: q=%h required=%h", q, 8'h00);
    end
    d     = 8'hFF;
    clear = 1'b0;
    exp_q.push_back(8'h00);
    @(posedge clk);
    #1;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL async_reset_hold_sb: scoreboard empty, q=%h", q);
    end else begin
      exp_v = exp_q.pop_front();
      if (q !== exp_v) begin
        failures++;
        $display("FAIL async_reset_hold: q=%h required=%h", q, exp_v);
      end
    end
    // Unknown inputs must not leak through while reset is held.
    d     = 8'hxx;
    clear = 1'bx;
    exp_q.push_back(8'h00);
    @(posedge clk);
    #1;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL reset_x_inputs_sb: scoreboard empty, q=%h", q);
    end else begin
      exp_v = exp_q.pop_front();
      if (q !== exp_v) begin
        failures++;
        $display("FAIL reset_x_inputs: q=%h required=%h", q, exp_v);
      end
    end
  endtask

  task automatic test_priority();
    @(negedge clk);
    reset = 1'b1;
    clear = 1'b0;
    d     = 8'hC3;
    exp_q.push_back(8'hC3);
    @(posedge clk);
    #1;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL prio_preload_sb: scoreboard empty, q=%h", q);
    end else begin
      exp_v = exp_q.pop_front();
      if (q !== exp_v) begin
        failures++;
        $display("FAIL prio_preload: q=%h required=%h", q, exp_v);
      end
    end
    d = 8'h99;
    @(posedge clk);
    reset = 1'b0;
    clear = 1'b1;
    #1;
    checks++;
    if (q !== 8'h00) begin
      failures++;
      $display("FAIL prio_reset_clear_edge: q=%h required=%h", q, 8'h00);
    end
    @(negedge clk);
    reset = 1'b1;
    clear = 1'b0;
    d     = 8'h5A;
    exp_q.push_back(8'h5A);
    @(posedge clk);
    #1;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL prio_release_load_sb: scoreboard empty, q=%h", q);
    end else begin
      exp_v = exp_q.pop_front();
      if (q !== exp_v) begin
        failures++;
        $display("FAIL prio_release_load: q=%h required=%h", q, exp_v);
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      d = 8'(i);
      exp_q.push_back(8'(i));
      @(posedge clk);
      #1;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL stream_%0d_sb: scoreboard empty, q=%h", i, q);
      end else begin
        exp_v = exp_q.pop_front();
        if (q !== exp_v) begin
          failures++;
          $display("FAIL stream_%0d: q=%h required=%h", i, q, exp_v);
        end
      end
    end
    #1;
    d = 8'hEE;
    #1;
    checks++;
    if (q !== 8'h03) begin
      failures++;
      $display("FAIL glitch_between_edges: q=%h required=%h", q, 8'h03);
    end
    @(negedge clk);
    d = 8'h04;
    exp_q.push_back(8'h04);
    @(posedge clk);
    #1;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL glitch_not_captured_sb: scoreboard empty, q=%h", q);
    end else begin
      exp_v = exp_q.pop_front();
      if (q !== exp_v) begin
        failures++;
        $display("FAIL glitch_not_captured: q=%h required=%h", q, exp_v);
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drained: entries=%0d required=0", exp_q.size());
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_release_load();
    test_sync_clear();
    test_async_reset();
    test_priority();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_flop_rc

`default_nettype wire
